uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter DATA_W, default 8, meaning data bits per frame (8N1 framing; LSB first).
REQ-002 Parameter SYNC_STAGES, default 2, meaning flip-flop depth of the rx input synchroniser.
REQ-003 aclk  input  1  only clock; every flop in the block is clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset sampled on rising aclk.
REQ-005 rx  input  1  asynchronous serial line; idle level 1.
REQ-006 prescale  input  16  oversample divider; bit period = prescale*8 aclk cycles; value 0 is treated as 1.
REQ-007 m_tdata  output  DATA_W  received byte.
REQ-008 m_tvalid  output  1  m_tdata holds an unconsumed byte.
REQ-009 m_tready  input  1  consumer accepts the byte.
REQ-010 rx_full  output  1  equals m_tvalid; drives the peer transmitter's tx_ready through an inverter.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 frame_error  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-013 overrun_error  output  1  one-cycle pulse: a byte completed while the output register was still full.

Function
REQ-014 rx shall pass through SYNC_STAGES flops, each reset to 1; rx_s is the synchroniser output, and all decisions use rx_s only.
REQ-015 The FSM shall have states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 prescale shall be latched into an internal register on the IDLE->START transition and held constant for the rest of the frame.
REQ-017 IDLE: when rx_s==0, the FSM shall go to START and load the bit counter with prescale_l*4-1 (half a bit period).
REQ-018 Each state other than IDLE and WAIT_HIGH shall decrement the counter every cycle and act only on the cycle the counter equals 0 ("expiry").
REQ-019 START expiry: if rx_s==0, go to DATA with counter = prescale_l*8-1 and bit index = 0; if rx_s==1, go to IDLE with no flag and no output (glitch rejection).
REQ-020 DATA expiry: shift rx_s into shift-register bit [bit index]; after bit DATA_W-1 go to STOP, otherwise increment the index; in both cases reload counter = prescale_l*8-1.
REQ-021 STOP expiry with rx_s==1: complete the byte and go to IDLE.
REQ-022 STOP expiry with rx_s==0: pulse frame_error, discard the byte, and go to WAIT_HIGH.
REQ-023 WAIT_HIGH shall go to IDLE on the first cycle rx_s==1; a held break shall not start a new frame.
REQ-024 Completion with m_tvalid==0, or with m_tvalid==1 and m_tready==1 in the same cycle, shall load m_tdata and set m_tvalid on the next edge; no overrun is flagged.
REQ-025 Completion with m_tvalid==1 and m_tready==0 shall pulse overrun_error, drop the new byte, and leave m_tdata and m_tvalid unchanged.
REQ-026 A handshake (m_tvalid & m_tready) with no completion in the same cycle shall clear m_tvalid on the next edge.
REQ-027 m_tdata shall stay stable while m_tvalid==1 and m_tready==0.
REQ-028 Counter arithmetic shall be 19 bits wide with no overflow for prescale up to 65535.
REQ-029 Latency: m_tvalid shall rise exactly 1 cycle after stop-bit expiry; stop-bit expiry falls SYNC_STAGES + prescale*(4+8*(DATA_W+1)) cycles after the falling edge of rx (±1 cycle sampling skew).

Reset
REQ-030 On reset: FSM = IDLE, counters = 0, synchroniser flops = 1, m_tdata = 0, m_tvalid = 0, busy = 0, frame_error = 0, overrun_error = 0.
REQ-031 Reset asserted mid-frame shall abort the frame with no flags; after release, the FSM shall wait in IDLE for the next falling edge of rx_s.

Verification
REQ-032 prescale=1, m_tready=1, send 0xA5 8N1 (8 cycles/bit) -> m_tdata=0xA5 with m_tvalid high for exactly 1 cycle; frame_error=0, overrun_error=0.
REQ-033 prescale=1, rx low for 3 cycles then high -> FSM returns to IDLE from START; no m_tvalid, no flags; busy high for at most 4 cycles.
REQ-034 prescale=1, send 0x3C with stop bit=0, then hold rx low for 40 cycles, then rx=1 -> frame_error pulses once; m_tvalid stays 0; no new frame starts until rx returns high.
REQ-035 m_tready=0, send 0x11 then 0x22 -> m_tdata=0x11 held, overrun_error pulses once at 0x22 completion; raise m_tready -> 0x11 consumed and m_tvalid=0.
REQ-036 Two cross-wired instances per the axi_uart test topology (prescale=1, consumer m_tready=1), 256 back-to-back bytes 0x00..0xFF -> all received in order, zero errors; repeat with prescale=3 and reset pulsed mid-byte -> clean recovery and the next byte is correct.

Source files
------------

// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core_if
// Description : Output byte stream of the UART receiver. It carries the data
//               word, the valid flag and the consumer's ready flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_core_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;

  // The receiver produces bytes and the consumer returns ready.
  modport master (output m_tdata, output m_tvalid, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, output m_tready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 UART receiver (LSB first). It oversamples by prescale*8
//               clocks per bit, samples each bit at mid-period, and presents
//               each received byte on a one-deep valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic        aclk,
  input  wire logic        reset,
  input  wire logic        rx,
  input  wire logic [15:0] prescale,
  uart_rx_core_if.master   m_axis,
  output logic             rx_full,
  output logic             busy,
  output logic             frame_error,
  output logic             overrun_error
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [18:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [15:0]         prescale_l_q, prescale_l_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DATA_W-1:0]   tdata_q;
  logic                tvalid_q;
  logic                ferr_q, ovr_q;

  logic                rx_s;
  logic                expire;
  logic                complete;
  logic                ferr_d;
  logic [15:0]         prescale_eff;
  logic [18:0]         bit_len;

  // A prescale of zero would give a zero-length bit, so it runs as one.
  assign prescale_eff = (prescale == 16'd0) ? 16'd1 : prescale;
  // One full bit period minus one, taken from the prescale latched for this frame.
  assign bit_len      = {prescale_l_q, 3'b000} - 19'd1;
  assign rx_s         = sync_q[SYNC_STAGES-1];
  assign expire       = (cnt_q == 19'd0);

  // Metastability synchroniser on the asynchronous line. It resets to idle-high.
  always_ff @(posedge aclk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= (sync_q << 1) | SYNC_STAGES'(rx);
  end

  // Registers for the frame state, bit timer, bit index, shifter and latched prescale.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      prescale_l_q <= 16'd1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      prescale_l_q <= prescale_l_d;
    end
  end

  // Frame sequencing. Timed states act only when their bit timer reaches zero.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    prescale_l_d = prescale_l_q;
    complete     = 1'b0;
    ferr_d       = 1'b0;

    if (state_q != IDLE && state_q != WAIT_HIGH) cnt_d = cnt_q - 19'd1;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d      = START;
          prescale_l_d = prescale_eff;
          // Wait half a bit so the start bit is checked at its centre.
          cnt_d        = {1'b0, prescale_eff, 2'b00} - 19'd1;
        end
      end
      START: begin
        if (expire) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = bit_len;
            idx_d   = '0;
          end else begin
            // The line is high again at mid start bit: treat it as a glitch.
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = bit_len;
          if (idx_q == C_LAST_IDX) state_d = STOP;
          else                     idx_d   = idx_q + IDX_W'(1);
        end
      end
      STOP: begin
        if (expire) begin
          cnt_d = '0;
          if (rx_s) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            // Framing error or break: hold off until the line returns high.
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One-deep output register. A full register drops the new byte and flags an overrun.
  always_ff @(posedge aclk) begin
    if (reset) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      ovr_q  <= 1'b0;
      if (complete) begin
        if (!tvalid_q || m_axis.m_tready) begin
          tdata_q  <= shift_q;
          tvalid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (tvalid_q && m_axis.m_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis.m_tdata  = tdata_q;
  assign m_axis.m_tvalid = tvalid_q;
  assign rx_full         = tvalid_q;
  assign busy            = (state_q != IDLE);
  assign frame_error     = ferr_q;
  assign overrun_error   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Directed self-checking bench for uart_rx_core. A behavioural
//               8N1 transmitter drives rx, and a monitor logs accepted bytes,
//               error pulses and busy run lengths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic        aclk     = 1'b0;
  logic        reset    = 1'b1;
  logic        rx       = 1'b1;
  logic [15:0] prescale = 16'd1;
  logic        rx_full, busy, frame_error, overrun_error;

  uart_rx_core_if #(.DATA_W(DATA_W)) axis_if ();

  uart_rx_core #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .aclk          (aclk),
    .reset         (reset),
    .rx            (rx),
    .prescale      (prescale),
    .m_axis        (axis_if),
    .rx_full       (rx_full),
    .busy          (busy),
    .frame_error   (frame_error),
    .overrun_error (overrun_error)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Monitor state.
  int         cyc = 0;
  logic [7:0] rxq[$];
  int         valid_cycles = 0, ferr_cnt = 0, ovr_cnt = 0;
  int         busy_run = 0, busy_len_last = 0, rise_cyc = 0;
  logic       valid_prev = 1'b0;
  int         t_fall = 0;

  // Count rising clock edges so latency can be measured.
  always @(posedge aclk) cyc <= cyc + 1;

  // Log accepted bytes, error pulses and busy run lengths away from the active edge.
  always @(negedge aclk) begin
    if (axis_if.m_tvalid && axis_if.m_tready) rxq.push_back(axis_if.m_tdata);
    if (axis_if.m_tvalid) valid_cycles++;
    if (axis_if.m_tvalid && !valid_prev) rise_cyc = cyc;
    valid_prev = axis_if.m_tvalid;
    if (frame_error) ferr_cnt++;
    if (overrun_error) ovr_cnt++;
    if (busy) busy_run++;
    else begin
      if (busy_run != 0) busy_len_last = busy_run;
      busy_run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Behavioural 8N1 transmitter. With honor set it waits for tx_ready (= ~rx_full).
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int p, input bit honor);
    int bc;
    int w;
    bc = p * 8;
    w  = 0;
    if (honor) begin
      while (rx_full && w < 2000) begin tick(1); w++; end
      if (rx_full) begin
        checks++; errors++;
        $display("FAIL tx_ready_timeout rx_full still %0b after %0d cycles, need 0", rx_full, w);
      end
    end
    rx = 1'b0; t_fall = cyc; tick(bc);
    for (int i = 0; i < 8; i++) begin rx = d[i]; tick(bc); end
    rx = stop_v; tick(bc);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(3);
    @(negedge aclk);
    checks++; if (axis_if.m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b exp 0", axis_if.m_tvalid); end
    checks++; if (axis_if.m_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got %0h exp 00", axis_if.m_tdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %0b exp 0", frame_error); end
    checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL reset_ovr got %0b exp 0", overrun_error); end
    checks++; if (rx_full !== 1'b0) begin errors++; $display("FAIL reset_rx_full got %0b exp 0", rx_full); end
    tick(1); reset = 1'b0; tick(3);
  endtask

  task automatic test_basic(input logic [15:0] ps, input logic [7:0] d, input string nm);
    int n0, v0, f0, o0, lat, exp_lat;
    n0 = rxq.size(); v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
    prescale = ps; axis_if.m_tready = 1'b1;
    send_frame(d, 1'b1, 1, 1'b1);
    tick(12);
    @(negedge aclk);
    lat     = rise_cyc - t_fall;
    exp_lat = 1 + SYNC_STAGES + 1 * (4 + 8 * (DATA_W + 1));
    checks++; if (rxq.size() - n0 !== 1) begin errors++; $display("FAIL %s_count got %0d exp 1", nm, rxq.size() - n0); end
    if (rxq.size() > n0) begin
      checks++; if (rxq[n0] !== d) begin errors++; $display("FAIL %s_data got %0h exp %0h", nm, rxq[n0], d); end
    end
    checks++; if (valid_cycles - v0 !== 1) begin errors++; $display("FAIL %s_valid_len got %0d exp 1", nm, valid_cycles - v0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL %s_ferr got %0d exp 0", nm, ferr_cnt - f0); end
    checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL %s_ovr got %0d exp 0", nm, ovr_cnt - o0); end
    checks++; if (lat < exp_lat - 1 || lat > exp_lat + 1) begin errors++; $display("FAIL %s_latency got %0d exp %0d+-1", nm, lat, exp_lat); end
    tick(1);
    prescale = 16'd1;
  endtask

  task automatic test_glitch();
    int n0, f0, o0;
    n0 = rxq.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    prescale = 16'd1;
    rx = 1'b0; tick(3); rx = 1'b1; tick(20);
    @(negedge aclk);
    checks++; if (rxq.size() - n0 !== 0) begin errors++; $display("FAIL glitch_count got %0d exp 0", rxq.size() - n0); end
    checks++; if (ferr_cnt - f0 + ovr_cnt - o0 !== 0) begin errors++; $display("FAIL glitch_flags got %0d exp 0", ferr_cnt - f0 + ovr_cnt - o0); end
    checks++; if (busy_len_last < 1 || busy_len_last > 4) begin errors++; $display("FAIL glitch_busy_len got %0d exp 1..4", busy_len_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got %0b exp 0", busy); end
    tick(1);
  endtask

  task automatic test_frame_error();
    int n0, v0, f0;
    n0 = rxq.size(); v0 = valid_cycles; f0 = ferr_cnt;
    prescale = 16'd1;
    send_frame(8'h3C, 1'b0, 1, 1'b1);
    tick(40);
    @(negedge aclk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_hold_busy got %0b exp 1", busy); end
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulse_in_break got %0d exp 1", ferr_cnt - f0); end
    tick(1);
    rx = 1'b1; tick(30);
    @(negedge aclk);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses got %0d exp 1", ferr_cnt - f0); end
    checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL ferr_valid got %0d exp 0", valid_cycles - v0); end
    checks++; if (rxq.size() - n0 !== 0) begin errors++; $display("FAIL ferr_count got %0d exp 0", rxq.size() - n0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_idle got %0b exp 0", busy); end
    tick(1);
    send_frame(8'h5A, 1'b1, 1, 1'b1);
    tick(12);
    @(negedge aclk);
    checks++; if (rxq.size() - n0 !== 1) begin errors++; $display("FAIL ferr_recover_count got %0d exp 1", rxq.size() - n0); end
    if (rxq.size() > n0) begin
      checks++; if (rxq[n0] !== 8'h5A) begin errors++; $display("FAIL ferr_recover_data got %0h exp 5a", rxq[n0]); end
    end
    tick(1);
  endtask

  task automatic test_overrun();
    int n0, o0;
    n0 = rxq.size(); o0 = ovr_cnt;
    prescale = 16'd1; axis_if.m_tready = 1'b0;
    send_frame(8'h11, 1'b1, 1, 1'b0);
    send_frame(8'h22, 1'b1, 1, 1'b0);
    rx = 1'b1; tick(10);
    @(negedge aclk);
    checks++; if (axis_if.m_tvalid !== 1'b1) begin errors++; $display("FAIL ovr_tvalid got %0b exp 1", axis_if.m_tvalid); end
    checks++; if (axis_if.m_tdata !== 8'h11) begin errors++; $display("FAIL ovr_tdata got %0h exp 11", axis_if.m_tdata); end
    checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ovr_cnt - o0); end
    checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL ovr_rx_full got %0b exp 1", rx_full); end
    @(posedge aclk); #1;
    axis_if.m_tready = 1'b1;
    tick(2);
    @(negedge aclk);
    checks++; if (axis_if.m_tvalid !== 1'b0) begin errors++; $display("FAIL ovr_drain_tvalid got %0b exp 0", axis_if.m_tvalid); end
    checks++; if (rxq.size() - n0 !== 1) begin errors++; $display("FAIL ovr_drain_count got %0d exp 1", rxq.size() - n0); end
    if (rxq.size() > n0) begin
      checks++; if (rxq[n0] !== 8'h11) begin errors++; $display("FAIL ovr_drain_data got %0h exp 11", rxq[n0]); end
    end
    tick(1);
  endtask

  task automatic test_back_to_back();
    int n0, f0, o0, bad;
    n0 = rxq.size(); f0 = ferr_cnt; o0 = ovr_cnt; bad = 0;
    prescale = 16'd1; axis_if.m_tready = 1'b1;
    for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1, 1, 1'b1);
    rx = 1'b1; tick(12);
    @(negedge aclk);
    checks++; if (rxq.size() - n0 !== 256) begin errors++; $display("FAIL b2b_count got %0d exp 256", rxq.size() - n0); end
    for (int i = 0; i < 256; i++)
      if (n0 + i < rxq.size() && rxq[n0 + i] !== 8'(i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_order got %0d wrong bytes exp 0", bad); end
    checks++; if (ferr_cnt - f0 + ovr_cnt - o0 !== 0) begin errors++; $display("FAIL b2b_flags got %0d exp 0", ferr_cnt - f0 + ovr_cnt - o0); end
    tick(1);

    // prescale=3: abort a frame with reset part way through its data bits.
    n0 = rxq.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    prescale = 16'd3;
    rx = 1'b0; tick(24); rx = 1'b1; tick(24); rx = 1'b0; tick(10);
    reset = 1'b1; rx = 1'b1; tick(2); reset = 1'b0; tick(5);
    @(negedge aclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", busy); end
    checks++; if (axis_if.m_tvalid !== 1'b0) begin errors++; $display("FAIL abort_tvalid got %0b exp 0", axis_if.m_tvalid); end
    tick(1);
    send_frame(8'hC3, 1'b1, 3, 1'b1);
    rx = 1'b1; tick(20);
    @(negedge aclk);
    checks++; if (rxq.size() - n0 !== 1) begin errors++; $display("FAIL abort_recover_count got %0d exp 1", rxq.size() - n0); end
    if (rxq.size() > n0) begin
      checks++; if (rxq[n0] !== 8'hC3) begin errors++; $display("FAIL abort_recover_data got %0h exp c3", rxq[n0]); end
    end
    checks++; if (ferr_cnt - f0 + ovr_cnt - o0 !== 0) begin errors++; $display("FAIL abort_flags got %0d exp 0", ferr_cnt - f0 + ovr_cnt - o0); end
    tick(1);
  endtask

  initial begin
    axis_if.m_tready = 1'b1;
    test_reset();
    test_basic(16'd1, 8'hA5, "basic_a5");
    test_basic(16'd0, 8'h81, "prescale0");
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Stop the run if something hangs.
  initial begin
    #2000000;
    $display("FAIL global_timeout reached at cycle %0d, need completion", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
